// File: rtl/pcie_rx_cpld_router_if.sv
// Completion-routing bus: one inbound completion beat stream fanned out to
// per-channel completion FIFO write ports, plus error and statistics outputs.
interface pcie_rx_cpld_router_if #(
    parameter int C_PCIE_DATA_WIDTH = 512,
    parameter int C_NUM_CH          = 4
);
    logic [7:0]                            cpld_fifo_tag;
    logic                                  cpld_fifo_tag_last;
    logic                                  cpld_fifo_wr_en;
    logic [C_PCIE_DATA_WIDTH-1:0]          cpld_fifo_wr_data;
    logic                                  err_clr;

    logic [8*C_NUM_CH-1:0]                 ch_fifo_tag;
    logic [C_NUM_CH-1:0]                   ch_fifo_tag_last;
    logic [C_NUM_CH-1:0]                   ch_fifo_wr_en;
    logic [C_PCIE_DATA_WIDTH*C_NUM_CH-1:0] ch_fifo_wr_data;
    logic [C_NUM_CH-1:0]                   ch_tag_done;
    logic                                  err_unmapped;
    logic                                  err_seq;
    logic [16*C_NUM_CH-1:0]                ch_beat_cnt;

    modport master (
        output cpld_fifo_tag, cpld_fifo_tag_last, cpld_fifo_wr_en,
        output cpld_fifo_wr_data, err_clr,
        input  ch_fifo_tag, ch_fifo_tag_last, ch_fifo_wr_en,
        input  ch_fifo_wr_data, ch_tag_done, err_unmapped, err_seq,
        input  ch_beat_cnt
    );

    modport slave (
        input  cpld_fifo_tag, cpld_fifo_tag_last, cpld_fifo_wr_en,
        input  cpld_fifo_wr_data, err_clr,
        output ch_fifo_tag, ch_fifo_tag_last, ch_fifo_wr_en,
        output ch_fifo_wr_data, ch_tag_done, err_unmapped, err_seq,
        output ch_beat_cnt
    );
endinterface

// File: rtl/pcie_rx_cpld_router.sv
// Routes completion beats to per-channel FIFOs by tag, one registered cycle.
// Define CPLD_ROUTER_STATS_EN to build the saturating per-channel beat counters.
module pcie_rx_cpld_router #(
    parameter int C_PCIE_DATA_WIDTH = 512,
    parameter int C_NUM_CH          = 4,
    parameter int C_TAG_CH_LSB      = 5
) (
    input  logic                  pcie_user_clk,
    input  logic                  pcie_user_rst_n,
    pcie_rx_cpld_router_if.slave  bus
);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    logic [7:0]          w_idx;
    logic                w_mapped;
    logic                w_hit;
    logic [C_NUM_CH-1:0] w_sel;

    logic [C_NUM_CH-1:0]                        r_wr_en;
    logic [C_NUM_CH-1:0]                        r_last;
    logic [C_NUM_CH-1:0]                        r_done;
    logic [C_NUM_CH-1:0][7:0]                   r_tag;
    logic [C_NUM_CH-1:0][C_PCIE_DATA_WIDTH-1:0] r_data;

    state_t     r_state;
    logic [7:0] r_lock_tag;
    logic       r_err_seq;
    logic       r_err_unmapped;

    assign w_idx    = bus.cpld_fifo_tag >> C_TAG_CH_LSB;
    assign w_mapped = (w_idx < 8'(C_NUM_CH));
    assign w_hit    = bus.cpld_fifo_wr_en & w_mapped;

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < C_NUM_CH; k++) begin
            w_sel[k] = w_hit && (w_idx == 8'(k));
        end
    end

    // Unselected slices keep their last routed tag/data/last.
    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            r_wr_en <= '0;
            r_last  <= '0;
            r_done  <= '0;
            r_tag   <= '0;
            r_data  <= '0;
        end else begin
            r_wr_en <= w_sel;
            r_done  <= w_sel & {C_NUM_CH{bus.cpld_fifo_tag_last}};
            for (int k = 0; k < C_NUM_CH; k++) begin
                if (w_sel[k]) begin
                    r_tag[k]  <= bus.cpld_fifo_tag;
                    r_data[k] <= bus.cpld_fifo_wr_data;
                    r_last[k] <= bus.cpld_fifo_tag_last;
                end
            end
        end
    end

    // Sequence tracker; a new error event overrides err_clr in the same cycle.
    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            r_state        <= S_IDLE;
            r_lock_tag     <= '0;
            r_err_seq      <= 1'b0;
            r_err_unmapped <= 1'b0;
        end else begin
            if (bus.err_clr) begin
                r_err_seq      <= 1'b0;
                r_err_unmapped <= 1'b0;
            end
            if (bus.cpld_fifo_wr_en) begin
                if (!w_mapped) begin
                    r_err_unmapped <= 1'b1;
                end
                unique case (r_state)
                    S_IDLE: begin
                        if (!bus.cpld_fifo_tag_last) begin
                            r_state    <= S_BURST;
                            r_lock_tag <= bus.cpld_fifo_tag;
                        end
                    end
                    S_BURST: begin
                        if (bus.cpld_fifo_tag != r_lock_tag) begin
                            r_err_seq  <= 1'b1;
                            r_lock_tag <= bus.cpld_fifo_tag;
                        end
                        if (bus.cpld_fifo_tag_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.ch_fifo_wr_en    = r_wr_en;
    assign bus.ch_fifo_tag_last = r_last;
    assign bus.ch_tag_done      = r_done;
    assign bus.ch_fifo_tag      = r_tag;
    assign bus.ch_fifo_wr_data  = r_data;
    assign bus.err_seq          = r_err_seq;
    assign bus.err_unmapped     = r_err_unmapped;

`ifdef CPLD_ROUTER_STATS_EN
    logic [C_NUM_CH-1:0][15:0] r_cnt;

    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            r_cnt <= '0;
        end else begin
            for (int k = 0; k < C_NUM_CH; k++) begin
                if (w_sel[k] && (r_cnt[k] != 16'hFFFF)) begin
                    r_cnt[k] <= r_cnt[k] + 16'd1;
                end
            end
        end
    end

    assign bus.ch_beat_cnt = r_cnt;
`else
    assign bus.ch_beat_cnt = '0;
`endif

endmodule

// File: doc/pcie_rx_cpld_router.md
PCIE_RX_CPLD_ROUTER -- requirements
Module: pcie_rx_cpld_router

Interface
REQ-001 Parameter C_PCIE_DATA_WIDTH, default 512, sets completion data beat width.
REQ-002 Parameter C_NUM_CH, default 4, legal 1..8, sets the number of completion channels.
REQ-003 Parameter C_TAG_CH_LSB, default 5, sets the lowest tag bit of the channel index field; channel index = tag >> C_TAG_CH_LSB.
REQ-004 pcie_user_clk  in  1  sole clock; all logic is rising-edge.
REQ-005 pcie_user_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 cpld_fifo_tag  in  8  tag of the current completion beat.
REQ-007 cpld_fifo_tag_last  in  1  final beat of this tag's completion.
REQ-008 cpld_fifo_wr_en  in  1  beat valid qualifier.
REQ-009 cpld_fifo_wr_data  in  C_PCIE_DATA_WIDTH  beat payload.
REQ-010 err_clr  in  1  single-cycle pulse that clears sticky error flags.
REQ-011 ch_fifo_tag  out  8*C_NUM_CH  per-channel tag; channel n occupies bits [8n+7:8n].
REQ-012 ch_fifo_tag_last  out  C_NUM_CH  per-channel last flag.
REQ-013 ch_fifo_wr_en  out  C_NUM_CH  per-channel write strobe.
REQ-014 ch_fifo_wr_data  out  C_PCIE_DATA_WIDTH*C_NUM_CH  per-channel payload; the slices are packed the same way as ch_fifo_tag.
REQ-015 ch_tag_done  out  C_NUM_CH  one-cycle pulse, asserted together with the routed last beat.
REQ-016 err_unmapped  out  1  sticky flag: a beat arrived with channel index >= C_NUM_CH.
REQ-017 err_seq  out  1  sticky flag: the tag changed inside a completion before tag_last.
REQ-018 ch_beat_cnt  out  16*C_NUM_CH  per-channel routed-beat counters.

Function
REQ-019 Routing SHALL be registered, with exactly one cycle of latency from input beat to output strobe.
REQ-020 A beat with wr_en=1 and index k<C_NUM_CH SHALL assert only ch_fifo_wr_en[k] on the next cycle, with tag, last and data copied to slice k.
REQ-021 ch_fifo_wr_en SHALL be strictly one-hot or zero in every cycle.
REQ-022 Data and tag slices of unselected channels SHALL hold their previous values.
REQ-023 A beat with index >=C_NUM_CH SHALL be dropped: no strobe and no counter change, and err_unmapped sets on the next cycle.
REQ-024 The FSM SHALL have two states, IDLE and BURST, with the locked tag register initialised to 0.
REQ-025 IDLE to BURST on a valid beat with tag_last=0, locking that beat's tag.
REQ-026 IDLE stays IDLE on a valid beat with tag_last=1.
REQ-027 BURST to IDLE on a valid beat with tag_last=1.
REQ-028 In BURST, a valid beat whose tag differs from the locked tag SHALL set err_seq, be routed by its own tag, and re-lock to the new tag; the state becomes BURST if its tag_last=0, otherwise IDLE.
REQ-029 Cycles with wr_en=0 SHALL leave the FSM, outputs and counters unchanged, apart from wr_en and tag_done deasserting.
REQ-030 If err_clr and a new error event occur in the same cycle, the error flag SHALL read 1 (set wins).
REQ-031 ch_beat_cnt[k] SHALL increment by 1 per routed beat and saturate at 16'hFFFF with no wrap.
REQ-032 When C_NUM_CH=1, every beat whose index is 0 SHALL route to channel 0.

Reset
REQ-033 Reset assertion SHALL immediately clear, without waiting for a clock edge:
- all wr_en, tag_last and tag_done outputs;
- both error flags;
- all beat counters;
- the tag and data slices, to 0;
- the FSM, to IDLE.
REQ-034 A reset during BURST SHALL discard the lock; the first beat after release is treated as coming from IDLE.
REQ-035 Reset deassertion SHALL take effect on the next rising clock edge, and no strobe SHALL be issued in the first cycle after release.

Configuration
REQ-036 With macro CPLD_ROUTER_STATS_EN defined, the ch_beat_cnt counters SHALL be implemented as REQ-031 states.
REQ-037 With CPLD_ROUTER_STATS_EN undefined, ch_beat_cnt SHALL be tied to 0, no counter flops SHALL exist, and all other behaviour is unchanged.

Verification
REQ-038 Default parameters. Input: beats with tag 8'h23 (index 1), last=0,0,1. Response: ch_fifo_wr_en[1] pulses on 3 consecutive cycles, each one cycle after its input beat; ch_tag_done[1] asserts on the third pulse only; ch_beat_cnt[1]=3.
REQ-039 Input: tag 8'hA0 with C_NUM_CH=4 (index 5). Response: no ch_fifo_wr_en asserted; err_unmapped=1 on the next cycle; err_clr pulse then reads 0.
REQ-040 Input: tag 8'h40 last=0, then tag 8'h41 last=1. Response: err_seq=1; both beats are routed to channel 2; the FSM ends in IDLE.
REQ-041 Input: tag 8'h00 last=0 beat, then reset asserted mid-cycle. Response: all outputs read 0 immediately; after release, a tag 8'h61 last=1 beat routes to channel 3 with err_seq=0.
REQ-042 With CPLD_ROUTER_STATS_EN defined, force channel 0's counter to 16'hFFFE, then drive 3 beats. Response: the counter holds at 16'hFFFF. With the macro undefined, the counter reads 0 throughout.
